// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
// Shared types and default sizes for the two-port data-RAM arbiter.
//   state_e    : sequencer states (IDLE, ISSUE, DONE)
//   port_e     : requester index (PORT0 = CPU, PORT1 = DMA/debug)
//   DEF_*      : default RAM depth, address width and data width
package ram_arbiter_pkg;

    localparam int DEF_DEPTH = 16;
    localparam int DEF_AW    = 32;
    localparam int DEF_DW    = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

endpackage : ram_arbiter_pkg

// File: rtl/ram_arb_pick.sv
// ram_arb_pick
// Combinational winner select for the two requesters.
//   RR_EN    : 1 = round-robin on a tie (the port not granted last wins),
//              0 = fixed priority (port 0 always wins a tie)
//   req0_i   : port 0 request
//   req1_i   : port 1 request
//   last_i   : port granted most recently
//   valid_o  : at least one request is pending
//   winner_o : port to grant (meaningful only with valid_o)
module ram_arb_pick
    import ram_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic  req0_i,
    input  logic  req1_i,
    input  port_e last_i,
    output logic  valid_o,
    output port_e winner_o
);

    always_comb begin
        valid_o  = req0_i | req1_i;
        winner_o = PORT0;
        if (req0_i && req1_i) begin
            // On a tie port 0 wins unless round-robin is on and port 0 was served last.
            if (RR_EN && (last_i == PORT0)) begin
                winner_o = PORT1;
            end
        end else if (req1_i) begin
            winner_o = PORT1;
        end
    end

endmodule : ram_arb_pick

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Serialises load/store traffic from two requesters (port 0 = CPU,
// port 1 = DMA/debug) onto a single-ported data RAM that samples on the
// falling clock edge. One access takes two cycles: ISSUE drives the RAM,
// DONE returns the result. Back-to-back accesses go DONE -> ISSUE directly.
//
// Build option: define RAM_ARB_RR_EN for round-robin arbitration on a tie;
// leave it undefined for fixed priority (port 0 always wins).
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req0/1, we0/1              request and write flag per port
//   addr0/1, wdata0/1          word address and write data per port
//   gnt0/1                     one-cycle pulse, request accepted
//   done0/1, err0/1            one-cycle completion pulse, out-of-range flag
//   rdata0/1                   read result, held until that port's next done
//   ram_r_en, ram_w_en         RAM enables (never both high)
//   ram_addr, ram_wdata        RAM address and write data
//   ram_rdata                  RAM read data, launched on the falling edge
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic          err0,
    output logic          err1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          ram_r_en,
    output logic          ram_w_en,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

`ifdef RAM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    state_e        state_q, state_d;
    port_e         win_q, win_d;       // port being served
    port_e         last_q, last_d;     // port granted most recently
    logic          cur_we_q, cur_we_d;
    logic          cur_oor_q, cur_oor_d;
    logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic          done0_q, done0_d, done1_q, done1_d;
    logic          err0_q, err0_d, err1_q, err1_d;
    logic          ram_r_en_q, ram_r_en_d, ram_w_en_q, ram_w_en_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic          pick_valid;
    port_e         pick_winner;
    logic          start;

    // Request fields of whichever port wins this cycle's arbitration.
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_oor;

    ram_arb_pick #(
        .RR_EN (RR_EN)
    ) u_pick (
        .req0_i   (req0),
        .req1_i   (req1),
        .last_i   (last_q),
        .valid_o  (pick_valid),
        .winner_o (pick_winner)
    );

    assign sel_we    = (pick_winner == PORT1) ? we1    : we0;
    assign sel_addr  = (pick_winner == PORT1) ? addr1  : addr0;
    assign sel_wdata = (pick_winner == PORT1) ? wdata1 : wdata0;
    assign sel_oor   = (sel_addr >= AW'(DEPTH));

    always_comb begin
        // NOTE: every next-state value gets a hold or idle default before the
        // case below, so no path through this block can infer a latch.
        state_d     = state_q;
        win_d       = win_q;
        last_d      = last_q;
        cur_we_d    = cur_we_q;
        cur_oor_d   = cur_oor_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        err0_d      = 1'b0;
        err1_d      = 1'b0;
        ram_r_en_d  = 1'b0;
        ram_w_en_d  = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        start       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                start = pick_valid;
            end
            ST_ISSUE: begin
                // RAM sampled on the falling edge of this cycle; its read data is ready now.
                state_d = ST_DONE;
                if (win_q == PORT0) begin
                    done0_d = 1'b1;
                    err0_d  = cur_oor_q;
                    if (!cur_we_q) begin
                        rdata0_d = cur_oor_q ? '0 : ram_rdata;
                    end
                end else begin
                    done1_d = 1'b1;
                    err1_d  = cur_oor_q;
                    if (!cur_we_q) begin
                        rdata1_d = cur_oor_q ? '0 : ram_rdata;
                    end
                end
            end
            ST_DONE: begin
                // A request still high here is a fresh one: re-arbitrate without idling.
                start = pick_valid;
                if (!pick_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start) begin
            state_d     = ST_ISSUE;
            win_d       = pick_winner;
            last_d      = pick_winner;
            cur_we_d    = sel_we;
            cur_oor_d   = sel_oor;
            gnt0_d      = (pick_winner == PORT0);
            gnt1_d      = (pick_winner == PORT1);
            ram_addr_d  = sel_addr;
            ram_wdata_d = sel_wdata;
            // Out-of-range accesses never touch the RAM; a write is simply dropped.
            ram_r_en_d  = !sel_we && !sel_oor;
            ram_w_en_d  = sel_we && !sel_oor;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            win_q       <= PORT0;
            last_q      <= PORT1;   // port 0 wins the first tie after reset
            cur_we_q    <= 1'b0;
            cur_oor_q   <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            ram_r_en_q  <= 1'b0;
            ram_w_en_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            last_q      <= last_d;
            cur_we_q    <= cur_we_d;
            cur_oor_q   <= cur_oor_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            ram_r_en_q  <= ram_r_en_d;
            ram_w_en_q  <= ram_w_en_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign ram_r_en  = ram_r_en_q;
    assign ram_w_en  = ram_w_en_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule : ram_arbiter
